z80_io_bridge: RTL

Z80_IO_BRIDGE -- requirements
Module: z80_io_bridge

---
 rtl/vdp_constants_pkg.sv | 13 +
 rtl/io_strobe_sync.sv | 38 +++
 rtl/z80_io_bridge.sv | 148 ++++++++++++++
 3 files changed

// File: rtl/vdp_constants_pkg.sv
// Shared VDP bridge constants: the bus-cycle FSM state encoding and the default I/O decode.
package vdp_constants;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_REQ     = 2'd1,
    ST_RELEASE = 2'd2
  } bridge_state_t;

  localparam logic [5:0] IO_BASE_DEFAULT     = 6'h26;
  localparam int         ACK_TIMEOUT_DEFAULT = 15;

endpackage

// File: rtl/io_strobe_sync.sv
// Two-flop synchroniser for an active-low Z80 strobe, plus a third flop for edge detection.
// Sync level lags the pad by 2 clocks; edges are suppressed until real samples fill the pipe.
module io_strobe_sync (
  input  logic clk,
  input  logic reset,
  input  logic i_strobe_n,
  output logic o_sync,
  output logic o_fall,
  output logic o_rise
);

  logic       r_s1;
  logic       r_s2;
  logic       r_s3;
  logic [1:0] r_fill;
  logic       w_armed;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_s1   <= 1'b1;
      r_s2   <= 1'b1;
      r_s3   <= 1'b1;
      r_fill <= 2'd0;
    end else begin
      r_s1 <= i_strobe_n;
      r_s2 <= r_s1;
      r_s3 <= r_s2;
      if (r_fill != 2'd3) r_fill <= r_fill + 2'd1;
    end
  end

  // A strobe held low across reset must not look like a fresh falling edge.
  assign w_armed = (r_fill == 2'd3);
  assign o_sync  = r_s2;
  assign o_fall  = w_armed & r_s3 & ~r_s2;
  assign o_rise  = w_armed & ~r_s3 & r_s2;

endmodule

// File: rtl/z80_io_bridge.sv
// Bridges asynchronous Z80 I/O cycles on ports IO_BASE*4..+3 to a single-cycle-ack VDP request.
// Request rises 3 clocks after the pad strobe falls; held until ack or ACK_TIMEOUT cycles.
module z80_io_bridge
  import vdp_constants::*;
#(
  parameter logic [5:0] IO_BASE     = IO_BASE_DEFAULT,
  parameter int         ACK_TIMEOUT = ACK_TIMEOUT_DEFAULT
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [5:0] A,
  input  logic       rd_iorq_n,
  input  logic       wr_iorq_n,
  input  logic [7:0] cd_in,
  output logic [7:0] cd_out,
  output logic       cd_oe,
  output logic       cs_n,
  output logic       vdp_io_req,
  output logic       vdp_io_wr,
  output logic [7:0] vdp_data_out,
  input  logic [7:0] vdp_data_in,
  input  logic       vdp_ack,
  output logic       timeout_err
);

  localparam logic [7:0] LP_TIMEOUT = ACK_TIMEOUT[7:0];

  bridge_state_t r_state;
  bridge_state_t w_next;

  logic       w_rd_sync;
  logic       w_rd_fall;
  logic       w_rd_rise;
  logic       w_wr_sync;
  logic       w_wr_fall;
  logic       w_unused_wr_rise;

  logic [7:0] r_cnt;
  logic       r_req;
  logic       r_wr;
  logic [7:0] r_dout;
  logic [7:0] r_cd_out;
  logic       r_oe;
  logic       r_tmo;
  logic       r_cs_n;

  logic       w_in_req;
  logic       w_start;
  logic       w_both_fall;
  logic [7:0] w_cnt_inc;
  logic       w_ack;
  logic       w_tmo;
  logic       w_done;

  io_strobe_sync u_rd_sync (
    .clk        (clk),
    .reset      (reset),
    .i_strobe_n (rd_iorq_n),
    .o_sync     (w_rd_sync),
    .o_fall     (w_rd_fall),
    .o_rise     (w_rd_rise)
  );

  // Write cycles end on the level check in RELEASE, so this edge has no consumer.
  io_strobe_sync u_wr_sync (
    .clk        (clk),
    .reset      (reset),
    .i_strobe_n (wr_iorq_n),
    .o_sync     (w_wr_sync),
    .o_fall     (w_wr_fall),
    .o_rise     (w_unused_wr_rise)
  );

  assign w_in_req    = (r_state == ST_REQ);
  assign w_both_fall = w_rd_fall & w_wr_fall;
  assign w_start     = (r_state == ST_IDLE) & (w_rd_fall ^ w_wr_fall) & (A == IO_BASE);
  assign w_cnt_inc   = (r_cnt == 8'hFF) ? r_cnt : r_cnt + 8'd1;
  assign w_ack       = w_in_req & vdp_ack;
  assign w_tmo       = w_in_req & ~vdp_ack & (w_cnt_inc == LP_TIMEOUT);
  assign w_done      = w_ack | w_tmo;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) r_state <= ST_IDLE;
    else       r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    unique case (r_state)
      ST_IDLE: begin
        if (w_both_fall)  w_next = ST_RELEASE;
        else if (w_start) w_next = ST_REQ;
      end
      ST_REQ: begin
        if (w_done) w_next = ST_RELEASE;
      end
      ST_RELEASE: begin
        if (w_rd_sync & w_wr_sync) w_next = ST_IDLE;
      end
      default: w_next = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_cnt    <= 8'd0;
      r_req    <= 1'b0;
      r_wr     <= 1'b0;
      r_dout   <= 8'd0;
      r_cd_out <= 8'hFF;
      r_oe     <= 1'b0;
      r_tmo    <= 1'b0;
      r_cs_n   <= 1'b1;
    end else begin
      r_tmo <= w_tmo;
      r_req <= (w_next == ST_REQ);

      if (w_start) begin
        r_cnt  <= 8'd0;
        r_wr   <= w_wr_fall;
        r_cs_n <= 1'b0;
        if (w_wr_fall) r_dout <= cd_in;
      end else if (w_in_req) begin
        r_cnt <= w_cnt_inc;
        if (w_done) r_wr <= 1'b0;
      end

      // Read data is driven only while the Z80 still holds its read strobe low.
      if (w_done & ~r_wr) begin
        r_cd_out <= w_ack ? vdp_data_in : 8'hFF;
        r_oe     <= ~w_rd_sync;
      end else if (w_rd_rise) begin
        r_oe <= 1'b0;
      end

      if ((r_state == ST_RELEASE) && (w_next == ST_IDLE)) r_cs_n <= 1'b1;
    end
  end

  assign vdp_io_req   = r_req;
  assign vdp_io_wr    = r_wr;
  assign vdp_data_out = r_dout;
  assign cd_out       = r_cd_out;
  assign cd_oe        = r_oe;
  assign cs_n         = r_cs_n;
  assign timeout_err  = r_tmo;

endmodule
